// File: rtl/weight_buffer_stream_ctrl.sv
// Streams row indices into the dual-half weight buffer for a programmed number of passes,
// carrying valid/row/pass tags that line up with the buffer's 2-cycle read output.
module weight_buffer_stream_ctrl #(
  parameter int NUM_ROWS    = 42,
  parameter int ROW_WIDTH   = 6,
  parameter int INDEX_WIDTH = 12,
  parameter int PASS_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [PASS_WIDTH-1:0]  num_passes,
  input  logic                   stall,
  output logic                   busy,
  output logic [INDEX_WIDTH-1:0] index,
  output logic                   data_valid,
  output logic [ROW_WIDTH-1:0]   out_row,
  output logic [PASS_WIDTH-1:0]  out_pass,
  output logic                   last_row,
  output logic                   done
);

  localparam logic [ROW_WIDTH-1:0] LAST_ROW = ROW_WIDTH'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [ROW_WIDTH-1:0]  ptr_row;
  logic [PASS_WIDTH-1:0] ptr_pass;
  logic [PASS_WIDTH-1:0] pass_last_q;

  logic                  vld_p0, vld_p1, vld_p2;
  logic [ROW_WIDTH-1:0]  row_p0, row_p1, row_p2;
  logic [PASS_WIDTH-1:0] pass_p0, pass_p1, pass_p2;
  logic                  last_p0, last_p1, last_p2;

  logic                  accept, reject, final_beat, start_ok, issue, issue_final;
  logic [ROW_WIDTH-1:0]  issue_row;
  logic [PASS_WIDTH-1:0] issue_pass, pass_last;

  // A start arriving in the same cycle as done is ignored.
  assign start_ok    = (state == IDLE) && start && !done;
  assign accept      = vld_p2 && !stall;
  assign reject      = vld_p2 && stall;
  assign final_beat  = accept && (row_p2 == LAST_ROW) && (pass_p2 == pass_last_q);
  assign issue       = (start_ok && (num_passes != '0)) || ((state == RUN) && !stall);
  assign issue_row   = (state == IDLE) ? '0 : ptr_row;
  assign issue_pass  = (state == IDLE) ? '0 : ptr_pass;
  assign pass_last   = (state == IDLE) ? (num_passes - PASS_WIDTH'(1)) : pass_last_q;
  assign issue_final = (issue_row == LAST_ROW) && (issue_pass == pass_last);

  assign index      = INDEX_WIDTH'(row_p0);
  assign data_valid = vld_p2;
  assign out_row    = row_p2;
  assign out_pass   = pass_p2;
  assign last_row   = last_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ptr_row     <= '0;
      ptr_pass    <= '0;
      pass_last_q <= '0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      vld_p2      <= 1'b0;
      row_p0      <= '0;
      row_p1      <= '0;
      row_p2      <= '0;
      pass_p0     <= '0;
      pass_p1     <= '0;
      pass_p2     <= '0;
      last_p0     <= 1'b0;
      last_p1     <= 1'b0;
      last_p2     <= 1'b0;
    end else begin
      done <= 1'b0;
      // S0 -> S1 -> S2: tags follow the buffer's address and output registers
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
      row_p1  <= row_p0;
      row_p2  <= row_p1;
      pass_p1 <= pass_p0;
      pass_p2 <= pass_p1;
      last_p1 <= last_p0;
      last_p2 <= last_p1;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;

      if (reject) begin
        // Everything behind the rejected beat is dropped; replay starts from it.
        vld_p1   <= 1'b0;
        vld_p2   <= 1'b0;
        last_p1  <= 1'b0;
        last_p2  <= 1'b0;
        ptr_row  <= row_p2;
        ptr_pass <= pass_p2;
        row_p0   <= row_p2;
        pass_p0  <= pass_p2;
        state    <= RUN;
      end else if (issue) begin
        vld_p0  <= 1'b1;
        row_p0  <= issue_row;
        pass_p0 <= issue_pass;
        last_p0 <= (issue_row == LAST_ROW);
        if (issue_row == LAST_ROW) begin
          ptr_row  <= '0;
          ptr_pass <= issue_pass + PASS_WIDTH'(1);
        end else begin
          ptr_row  <= issue_row + ROW_WIDTH'(1);
          ptr_pass <= issue_pass;
        end
        state <= issue_final ? DRAIN : RUN;
        if (state == IDLE) begin
          busy        <= 1'b1;
          pass_last_q <= pass_last;
        end
      end else if (start_ok) begin
        done <= 1'b1;
      end

      if ((state == DRAIN) && final_beat) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_buffer_stream_ctrl.sv
// Directed bench for weight_buffer_stream_ctrl with a queue-based scoreboard of (pass, row) beats.
module tb_weight_buffer_stream_ctrl;

  localparam int NR = 42;

  logic        clk = 1'b0;
  logic        reset, start, stall;
  logic [7:0]  num_passes;
  logic        busy, data_valid, last_row, done;
  logic [11:0] index;
  logic [5:0]  out_row;
  logic [7:0]  out_pass;

  weight_buffer_stream_ctrl #(
    .NUM_ROWS(NR), .ROW_WIDTH(6), .INDEX_WIDTH(12), .PASS_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_passes(num_passes), .stall(stall),
    .busy(busy), .index(index), .data_valid(data_valid), .out_row(out_row),
    .out_pass(out_pass), .last_row(last_row), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int row; int pass;} beat_t;
  beat_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive point: just after the rising edge. Stimulus decisions happen at +6, monitor at +7.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input int passes);
    for (int p = 0; p < passes; p++)
      for (int r = 0; r < NR; r++)
        sb.push_back('{row: r, pass: p});
  endtask

  task automatic pulse_start(input int passes);
    tick();
    start = 1'b1;
    num_passes = 8'(passes);
    push_run(passes);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int dc, input int budget);
    for (int i = 0; i < budget && done_cnt == dc; i++) tick();
    repeat (4) tick();
    check("done_once", done_cnt - dc, 1);
    check("sb_drained", sb.size(), 0);
  endtask

  // Monitor: every presented beat must be the oldest unaccepted one; pop on accept.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", data_valid, 0);
        end else begin
          check("out_row", out_row, sb[0].row);
          check("out_pass", out_pass, sb[0].pass);
          check("last_row", last_row, (sb[0].row == NR - 1) ? 1 : 0);
          if (stall === 1'b0) void'(sb.pop_front());
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("done_with_sb_empty", sb.size(), 0);
      end
    end
  end

  initial begin
    int dc;
    bit found;
    reset = 1'b1; start = 1'b0; stall = 1'b0; num_passes = '0;
    repeat (3) tick();
    reset = 1'b0;
    #5;
    check("rst_busy", busy, 0);
    check("rst_index", index, 0);
    check("rst_valid", data_valid, 0);
    check("rst_row", out_row, 0);
    check("rst_pass", out_pass, 0);
    check("rst_last", last_row, 0);
    check("rst_done", done, 0);

    // Single pass, exact cycle timing relative to start
    dc = done_cnt;
    tick();
    start = 1'b1; num_passes = 8'd1;
    push_run(1);
    for (int k = 1; k <= 46; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      #5;
      if (k <= NR) check("t1_index", index, k - 1);
      check("t1_valid", data_valid, (k >= 3 && k <= NR + 2) ? 1 : 0);
      check("t1_busy", busy, (k <= NR + 2) ? 1 : 0);
      check("t1_done", done, (k == NR + 3) ? 1 : 0);
    end
    check("t1_done_once", done_cnt - dc, 1);

    // Three passes with a start pulse mid-run that must be ignored
    dc = done_cnt;
    pulse_start(3);
    repeat (30) tick();
    start = 1'b1; num_passes = 8'd5;
    tick();
    start = 1'b0; num_passes = '0;
    wait_done(dc, 300);

    // One-cycle stall on row 10 of pass 0, then a three-cycle stall on row 20 of pass 1
    dc = done_cnt;
    pulse_start(2);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(); #5;
      if (data_valid && out_row == 10 && out_pass == 0) begin stall = 1'b1; found = 1; end
    end
    check("stall10_found", found, 1);
    tick(); stall = 1'b0; #5;
    check("stall10_flushed", data_valid, 0);
    repeat (3) tick();
    #5;
    check("replay10_valid", data_valid, 1);
    check("replay10_row", out_row, 10);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(); #5;
      if (data_valid && out_row == 20 && out_pass == 1) begin stall = 1'b1; found = 1; end
    end
    check("stall20_found", found, 1);
    repeat (3) tick();
    stall = 1'b0;
    wait_done(dc, 300);

    // Stall on the final beat while draining
    dc = done_cnt;
    pulse_start(1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick(); #5;
      if (data_valid && out_row == NR - 1) begin stall = 1'b1; found = 1; end
    end
    check("drain_stall_found", found, 1);
    tick(); stall = 1'b0; #5;
    check("drain_stall_busy", busy, 1);
    check("drain_stall_nodone", done, 0);
    wait_done(dc, 100);

    // Zero passes: done only
    dc = done_cnt;
    pulse_start(0);
    #5;
    check("zp_done", done, 1);
    check("zp_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      tick(); #5;
      check("zp_valid", data_valid, 0);
      check("zp_busy_hold", busy, 0);
      check("zp_done_clear", done, 0);
    end

    // Reset mid-pass aborts, then a fresh run restarts from row 0, pass 0
    pulse_start(2);
    repeat (20) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #5;
    sb.delete();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_index", index, 0);
    check("mid_rst_valid", data_valid, 0);
    check("mid_rst_row", out_row, 0);
    check("mid_rst_pass", out_pass, 0);
    check("mid_rst_last", last_row, 0);
    check("mid_rst_done", done, 0);
    dc = done_cnt;
    repeat (10) tick();
    check("mid_rst_no_done", done_cnt - dc, 0);
    pulse_start(1);
    wait_done(dc, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_buffer_stream_ctrl.md
# weight_buffer_stream_ctrl

Sequencer for the dual-half weight buffer (two 162-bit single-port ROMs, half 1 offset by 42 rows, 2-cycle `index`-to-`q` latency). On `start` it streams row indices 0..NUM_ROWS-1 into the buffer's `index` input for a programmable number of passes. It tracks every in-flight read with a valid/row/pass tag aligned to the buffer's `q_*` outputs. When the consumer stalls, it drops in-flight reads and replays from the first unaccepted row, so no row is lost or duplicated.

## Interface
Parameters:
- `NUM_ROWS`, 42, rows per pass; legal range 1..2^ROW_WIDTH.
- `ROW_WIDTH`, 6, width of row tags.
- `INDEX_WIDTH`, 12, width of `index` driven to the weight buffer.
- `PASS_WIDTH`, 8, width of the pass count.
- Read latency is fixed at 2 cycles and is not a parameter.

Ports:
- `clk`  in  1  single clock for the block.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a run; sampled only in IDLE.
- `num_passes`  in  PASS_WIDTH  number of passes, latched at `start`.
- `stall`  in  1  consumer cannot accept the beat presented this cycle.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `index`  out  INDEX_WIDTH  row address to the weight buffer, zero-extended.
- `data_valid`  out  1  `q_*` outputs of the buffer hold row `out_row` this cycle.
- `out_row`  out  ROW_WIDTH  row tag of the presented beat.
- `out_pass`  out  PASS_WIDTH  pass tag of the presented beat, 0-based.
- `last_row`  out  1  presented beat is row NUM_ROWS-1.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- Pipeline tags:
  - S0 = issue (`index` register, v0/row0/pass0).
  - S1 = buffer address register (v1/row1/pass1).
  - S2 = buffer output (v2/row2/pass2).
  - Tags advance every cycle.
  - `data_valid`=v2, `out_row`=row2, `out_pass`=pass2.
- A beat is accepted iff `data_valid` && !`stall`. It is rejected iff `data_valid` && `stall`.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start` with `num_passes`≠0: latch count, set issue pointer to row 0 / pass 0, go to RUN.
  - `start` with `num_passes`=0: `done` pulses the next cycle, state stays IDLE, no beats are issued.
- RUN:
  - Each cycle with `stall` low and no rejection: issue the pointer (v0=1), then advance it.
  - The row wraps from NUM_ROWS-1 to 0 and increments the pass.
  - After issuing row NUM_ROWS-1 of pass `num_passes`-1, go to DRAIN.
  - While `stall` is high, nothing is issued (v0=0) and the pointer holds.
- Rejection (RUN or DRAIN):
  - Next cycle: v0, v1 and v2 are cleared.
  - The issue pointer is set to row2/pass2 of the rejected beat; `index` is updated to that row.
  - State becomes RUN.
  - Issue resumes in the first cycle with `stall` low.
- DRAIN:
  - Nothing is issued.
  - When the final beat (last row, last pass) is accepted: `done`=1 next cycle, `busy` falls with it, state returns to IDLE.
- `start` while not in IDLE is ignored.
- `num_passes` is sampled only at `start`.
- Each (pass, row) pair is accepted exactly once, in ascending order.

## Timing
- Reset values:
  - State IDLE.
  - `busy`=0, `index`=0, `data_valid`=0, `out_row`=0, `out_pass`=0, `last_row`=0, `done`=0.
  - All v-tags 0.
- Reset asserted mid-run aborts immediately: no `done`, and in-flight tags are discarded.
- `start` at cycle t:
  - `busy`=1 and the first issue at t+1.
  - Row 0 presented with `data_valid` at t+3.
- Streaming throughput is one row per cycle with `stall` low.
- Unstalled run length: the final beat is at t+2+NUM_ROWS·P, and `done` at t+3+NUM_ROWS·P.
- Stall penalty: a rejected beat reappears at least 3 cycles after the first cycle with `stall` low following the rejection.
- `stall` with `data_valid` low has no effect on tags in flight; it only blocks new issue.
- `done` and `busy` falling occur in the same cycle; `start` in that cycle is ignored.

## Test plan
- Reset, `start` with `num_passes`=1 and `stall`=0:
  - `index` runs 0..41 on t+1..t+42.
  - `data_valid` is high t+3..t+44 with `out_row` 0..41; `last_row` is high at t+44.
  - `done` at t+45.
- `num_passes`=3, no stall: 126 beats with `out_pass` 0,1,2; rows wrap 41→0; `done` exactly once.
- `stall` high for one cycle when `out_row`=10:
  - Rows 11 and 12 are dropped.
  - The next valid beat is row 10 again, then 11, 12, …
  - Per pass, the accepted sequence is exactly 0..41.
- `stall` high during DRAIN on row 41 of the last pass: state replays to RUN, row 41 is re-presented, then `done`.
- `num_passes`=0: `done` pulses one cycle after `start`; `data_valid` and `busy` stay 0.
- Reset asserted mid-pass: all outputs return to reset values next cycle; a subsequent `start` restarts from row 0, pass 0.
